// File: rtl/nrisc_boot_pkg.sv
// Shared state encoding, error codes and frame constants for the nRisc boot loader.
package nrisc_boot_pkg;

   typedef enum logic [2:0] {IDLE, LEN, LOAD, CHECK, DONE, ERROR} state_t;

   localparam logic [1:0] ERR_NONE    = 2'd0;
   localparam logic [1:0] ERR_CSUM    = 2'd1;
   localparam logic [1:0] ERR_TIMEOUT = 2'd2;

   localparam logic [7:0] HEADER_DEFAULT = 8'hA5;
   localparam int         TMR_W          = 16;

   // A length byte of zero means a full 256-byte image.
   function automatic logic [8:0] frame_size(input logic [7:0] len);
      return (len == 8'd0) ? 9'd256 : {1'b0, len};
   endfunction

endpackage

// File: rtl/nrisc_boot_timeout.sv
// Mid-frame idle watchdog: counts enabled cycles, saturates at LIMIT and flags expiry.
// Clear wins over enable; expired is combinational from the count.
module nrisc_boot_timeout
   import nrisc_boot_pkg::*;
#(
   parameter int unsigned LIMIT = 65535
) (
   input  logic clock,
   input  logic reset_n,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam logic [TMR_W-1:0] LIMIT_V = TMR_W'(LIMIT);

   logic [TMR_W-1:0] count;

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable && !expired) begin
         count <= count + 1'b1;
      end
   end

   assign expired = (count == LIMIT_V);

endmodule

// File: rtl/nrisc_boot_loader.sv
// Framed image loader: writes payload to imem one cycle after the accept edge, releases core on good checksum.
// rx_ready drops only for a stalled echo byte (NRISC_BOOT_ECHO_EN); otherwise every byte is taken.
module nrisc_boot_loader
   import nrisc_boot_pkg::*;
#(
   parameter int                ADDR_W         = 8,
   parameter int                DATA_W         = 8,
   parameter logic [DATA_W-1:0] HEADER         = HEADER_DEFAULT,
   parameter int unsigned       TIMEOUT_CYCLES = 65535
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic [DATA_W-1:0] rx_data,
   input  logic              rx_valid,
   output logic              rx_ready,
   output logic              im_wr_en,
   output logic [ADDR_W-1:0] im_wr_addr,
   output logic [DATA_W-1:0] im_wr_data,
   output logic              core_hold,
   output logic              load_done,
   output logic              load_error,
   output logic [1:0]        error_code,
   output logic [8:0]        words_loaded,
   output logic [DATA_W-1:0] tx_data,
   output logic              tx_valid,
   input  logic              tx_ready
);

   state_t            state, state_nxt;
   logic              accept, in_frame, tmo_expired, echo_block;
   logic              start, ld_len, wr_byte, set_done, set_csum, set_tmo;
   logic [ADDR_W-1:0] addr, pend_addr;
   logic [DATA_W-1:0] sum, pend_data;
   logic [8:0]        remain;
   logic              wr_pend;

   assign accept   = rx_valid && rx_ready;
   assign rx_ready = reset_n && !echo_block;
   assign in_frame = (state == LEN) || (state == LOAD) || (state == CHECK);

   nrisc_boot_timeout #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
      .clock   (clock),
      .reset_n (reset_n),
      .clear   (!in_frame || accept),
      .enable  (in_frame),
      .expired (tmo_expired)
   );

   always_ff @(posedge clock) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      start     = 1'b0;
      ld_len    = 1'b0;
      wr_byte   = 1'b0;
      set_done  = 1'b0;
      set_csum  = 1'b0;
      set_tmo   = 1'b0;
      case (state)
         IDLE, DONE, ERROR: begin
            if (accept && rx_data == HEADER) begin
               start     = 1'b1;
               state_nxt = LEN;
            end
         end
         LEN: begin
            if (accept) begin
               ld_len    = 1'b1;
               state_nxt = LOAD;
            end else if (tmo_expired) begin
               set_tmo   = 1'b1;
               state_nxt = ERROR;
            end
         end
         LOAD: begin
            if (accept) begin
               wr_byte = 1'b1;
               if (remain == 9'd1) state_nxt = CHECK;
            end else if (tmo_expired) begin
               set_tmo   = 1'b1;
               state_nxt = ERROR;
            end
         end
         CHECK: begin
            if (accept) begin
               if (rx_data == sum) begin
                  set_done  = 1'b1;
                  state_nxt = DONE;
               end else begin
                  set_csum  = 1'b1;
                  state_nxt = ERROR;
               end
            end else if (tmo_expired) begin
               set_tmo   = 1'b1;
               state_nxt = ERROR;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Two-stage write path: capture on the accept edge, strobe the memory on the next edge.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         addr         <= '0;
         sum          <= '0;
         remain       <= '0;
         wr_pend      <= 1'b0;
         pend_addr    <= '0;
         pend_data    <= '0;
         im_wr_en     <= 1'b0;
         im_wr_addr   <= '0;
         im_wr_data   <= '0;
         words_loaded <= '0;
         core_hold    <= 1'b1;
         load_done    <= 1'b0;
         load_error   <= 1'b0;
         error_code   <= ERR_NONE;
      end else begin
         wr_pend  <= wr_byte;
         im_wr_en <= wr_pend;
         if (wr_byte) begin
            pend_addr <= addr;
            pend_data <= rx_data;
            addr      <= addr + 1'b1;
            sum       <= sum + rx_data;
            remain    <= remain - 9'd1;
         end
         if (wr_pend) begin
            im_wr_addr <= pend_addr;
            im_wr_data <= pend_data;
         end
         if (ld_len) begin
            addr         <= '0;
            sum          <= '0;
            remain       <= frame_size(rx_data);
            words_loaded <= '0;
         end else if (wr_pend) begin
            words_loaded <= words_loaded + 9'd1;
         end
         if (start) begin
            core_hold  <= 1'b1;
            load_done  <= 1'b0;
            load_error <= 1'b0;
            error_code <= ERR_NONE;
         end
         if (set_done) begin
            core_hold <= 1'b0;
            load_done <= 1'b1;
         end
         if (set_csum || set_tmo) begin
            core_hold  <= 1'b1;
            load_error <= 1'b1;
            error_code <= set_csum ? ERR_CSUM : ERR_TIMEOUT;
         end
      end
   end

`ifdef NRISC_BOOT_ECHO_EN
   logic              echo_vld;
   logic [DATA_W-1:0] echo_dat;

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         echo_vld <= 1'b0;
         echo_dat <= '0;
      end else if (accept) begin
         echo_vld <= 1'b1;
         echo_dat <= rx_data;
      end else if (tx_ready) begin
         echo_vld <= 1'b0;
      end
   end

   assign echo_block = echo_vld && !tx_ready;
   assign tx_valid   = echo_vld;
   assign tx_data    = echo_dat;
`else
   logic unused_tx_ready;

   assign unused_tx_ready = tx_ready;
   assign echo_block      = 1'b0;
   assign tx_valid        = 1'b0;
   assign tx_data         = '0;
`endif

endmodule

// File: tb/tb_nrisc_boot_loader.sv
// Randomized frame bench for nrisc_boot_loader with a frame-level reference model and echo scoreboard.
module tb_nrisc_boot_loader;

   localparam int TMO = 300;

   logic       clock, reset_n, rx_valid, rx_ready, im_wr_en;
   logic       core_hold, load_done, load_error, tx_valid, tx_ready;
   logic [7:0] rx_data, im_wr_addr, im_wr_data, tx_data;
   logic [1:0] error_code;
   logic [8:0] words_loaded;

   int checks = 0;
   int errors = 0;
   int tx_mode = 0;
   int tx_bad = 0;

   logic [15:0] wr_q[$];
   logic [7:0]  acc_q[$];
   logic [7:0]  echo_q[$];
   logic [7:0]  pay_q[$];

   nrisc_boot_loader #(.TIMEOUT_CYCLES(TMO)) dut (
      .clock        (clock),
      .reset_n      (reset_n),
      .rx_data      (rx_data),
      .rx_valid     (rx_valid),
      .rx_ready     (rx_ready),
      .im_wr_en     (im_wr_en),
      .im_wr_addr   (im_wr_addr),
      .im_wr_data   (im_wr_data),
      .core_hold    (core_hold),
      .load_done    (load_done),
      .load_error   (load_error),
      .error_code   (error_code),
      .words_loaded (words_loaded),
      .tx_data      (tx_data),
      .tx_valid     (tx_valid),
      .tx_ready     (tx_ready)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Everything observed on the negedge reflects what the next rising edge will transfer.
   always @(negedge clock) begin
      if (im_wr_en) wr_q.push_back({im_wr_addr, im_wr_data});
      if (rx_valid && rx_ready) acc_q.push_back(rx_data);
      if (tx_valid && tx_ready) echo_q.push_back(tx_data);
      if (tx_valid || tx_data != 8'h00) tx_bad++;
   end

   initial begin
      tx_ready = 1'b1;
      forever begin
         @(posedge clock);
         #1;
         case (tx_mode)
            0:       tx_ready = 1'b1;
            1:       tx_ready = ($urandom_range(0, 3) != 0);
            default: tx_ready = 1'b0;
         endcase
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1, "watchdog expired");
   end

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic idle(input int k);
      repeat (k) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      int n;
      n = 0;
      rx_data  = b;
      rx_valid = 1'b1;
      @(negedge clock);
      while (!rx_ready && n < 2000) begin
         @(negedge clock);
         n++;
      end
      if (n >= 2000) check_val("rx_ready_stall", rx_ready, 1);
      @(posedge clock);
      #1;
      rx_valid = 1'b0;
   endtask

   task automatic make_payload(input int n);
      pay_q.delete();
      for (int i = 0; i < n; i++)
         pay_q.push_back(($urandom_range(0, 7) == 0) ? 8'hA5 : 8'($urandom_range(0, 255)));
   endtask

   // Model: checksum is the mod-256 sum of the payload; a bad frame gets any other value.
   task automatic send_frame(input bit good, input int gap_max, input bit with_hdr);
      int s;
      s = 0;
      foreach (pay_q[i]) s += int'(pay_q[i]);
      if (with_hdr) begin
         send_byte(8'hA5);
         idle($urandom_range(0, gap_max));
      end
      send_byte((pay_q.size() == 256) ? 8'h00 : 8'(pay_q.size()));
      foreach (pay_q[i]) begin
         send_byte(pay_q[i]);
         idle($urandom_range(0, gap_max));
      end
      send_byte(good ? 8'(s) : 8'(s + 1 + int'($urandom_range(0, 253))));
   endtask

   task automatic check_frame(input bit good);
      idle(4);
      check_val("wr_count", wr_q.size(), pay_q.size());
      foreach (pay_q[i])
         if (i < wr_q.size()) check_val("wr_addr_data", {16'h0, wr_q[i]}, {16'h0, 8'(i), pay_q[i]});
      check_val("words_loaded", words_loaded, pay_q.size());
      check_val("load_done", load_done, good);
      check_val("load_error", load_error, !good);
      check_val("error_code", error_code, good ? 0 : 1);
      check_val("core_hold", core_hold, !good);
      wr_q.delete();
   endtask

   initial begin
      bit         good_f;
      int         nj;
      logic [7:0] jb;

      reset_n  = 1'b0;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      idle(3);
      check_val("rst_core_hold", core_hold, 1);
      check_val("rst_wr_en", im_wr_en, 0);
      check_val("rst_wr_addr", im_wr_addr, 0);
      check_val("rst_wr_data", im_wr_data, 0);
      check_val("rst_load_done", load_done, 0);
      check_val("rst_load_error", load_error, 0);
      check_val("rst_error_code", error_code, 0);
      check_val("rst_words", words_loaded, 0);
      check_val("rst_tx_valid", tx_valid, 0);
      check_val("rst_tx_data", tx_data, 0);
      check_val("rst_rx_ready", rx_ready, 0);
      reset_n = 1'b1;
      idle(2);
      check_val("ready_after_reset", rx_ready, 1);
      wr_q.delete();
      acc_q.delete();
      echo_q.delete();

      // Directed good frame with exact write-latency probes.
      pay_q.delete();
      pay_q.push_back(8'h11);
      pay_q.push_back(8'h22);
      pay_q.push_back(8'h33);
      send_byte(8'hA5);
      send_byte(8'h03);
      send_byte(8'h11);
      check_val("wr_lat_t0", im_wr_en, 0);
      idle(1);
      check_val("wr_lat_t1", im_wr_en, 1);
      check_val("wr_lat_addr_data", {im_wr_addr, im_wr_data}, 16'h0011);
      idle(1);
      check_val("wr_lat_t2", im_wr_en, 0);
      send_byte(8'h22);
      send_byte(8'h33);
      check_val("hold_before_csum", core_hold, 1);
      send_byte(8'h66);
      check_frame(1'b1);

      // Checksum mismatch, then a good frame clears the error.
      pay_q.delete();
      pay_q.push_back(8'h10);
      pay_q.push_back(8'h20);
      send_byte(8'hA5);
      send_byte(8'h02);
      send_byte(8'h10);
      send_byte(8'h20);
      send_byte(8'h31);
      check_frame(1'b0);
      make_payload(5);
      send_frame(1'b1, 1, 1'b1);
      check_frame(1'b1);

      // Full 256-byte image, address wraps with no extra write.
      pay_q.delete();
      for (int i = 0; i < 256; i++) pay_q.push_back(8'h01);
      send_frame(1'b1, 0, 1'b1);
      check_frame(1'b1);

      // Mid-frame idle timeout, then 55 discarded and A5 restarting the frame.
      pay_q.delete();
      pay_q.push_back(8'hAA);
      send_byte(8'hA5);
      send_byte(8'h04);
      send_byte(8'hAA);
      idle(TMO - 5);
      check_val("tmo_early", load_error, 0);
      idle(10);
      check_val("tmo_error_code", error_code, 2);
      check_val("tmo_load_error", load_error, 1);
      check_val("tmo_core_hold", core_hold, 1);
      check_val("tmo_words", words_loaded, 1);
      check_val("tmo_wr_count", wr_q.size(), 1);
      if (wr_q.size() > 0) check_val("tmo_wr_kept", wr_q[0], 16'h00AA);
      wr_q.delete();
      send_byte(8'h55);
      idle(2);
      check_val("tmo_55_discarded", error_code, 2);
      send_byte(8'hA5);
      idle(2);
      check_val("tmo_restart_code", error_code, 0);
      check_val("tmo_restart_err", load_error, 0);
      make_payload(3);
      send_frame(1'b1, 1, 1'b0);
      check_frame(1'b1);

      // Reset in the middle of a load drops the in-flight write.
      send_byte(8'hA5);
      send_byte(8'h05);
      send_byte(8'h01);
      send_byte(8'h02);
      reset_n = 1'b0;
      idle(1);
      check_val("mid_rst_wr_en", im_wr_en, 0);
      check_val("mid_rst_core_hold", core_hold, 1);
      check_val("mid_rst_done", load_done, 0);
      check_val("mid_rst_error", load_error, 0);
      check_val("mid_rst_code", error_code, 0);
      check_val("mid_rst_words", words_loaded, 0);
      check_val("mid_rst_addr_data", {im_wr_addr, im_wr_data}, 16'h0000);
      check_val("mid_rst_rx_ready", rx_ready, 0);
      check_val("mid_rst_tx_valid", tx_valid, 0);
      check_val("mid_rst_wr_count", wr_q.size(), 1);
      wr_q.delete();
      acc_q.delete();
      echo_q.delete();
      idle(1);
      reset_n = 1'b1;
      idle(1);
      send_byte(8'h12);
      send_byte(8'h34);
      make_payload(4);
      send_frame(1'b1, 1, 1'b1);
      check_frame(1'b1);

`ifdef NRISC_BOOT_ECHO_EN
      // Echo held under consumer backpressure; rx blocked meanwhile.
      tx_mode = 0;
      idle(3);
      tx_mode = 2;
      idle(2);
      send_byte(8'h3C);
      repeat (10) begin
         idle(1);
         check_val("echo_stall_rx_ready", rx_ready, 0);
         check_val("echo_stall_valid", tx_valid, 1);
         check_val("echo_stall_data", tx_data, 8'h3C);
      end
      tx_mode = 0;
      idle(3);
      check_val("echo_drained", tx_valid, 0);
`endif

      tx_mode = 1;
      for (int f = 0; f < 8; f++) begin
         nj = $urandom_range(0, 3);
         for (int j = 0; j < nj; j++) begin
            jb = 8'($urandom_range(0, 255));
            if (jb == 8'hA5) jb = 8'h5A;
            send_byte(jb);
         end
         make_payload($urandom_range(1, 48));
         good_f = ($urandom_range(0, 2) != 0);
         send_frame(good_f, 2, 1'b1);
         check_frame(good_f);
      end

      tx_mode = 0;
      idle(5);
`ifdef NRISC_BOOT_ECHO_EN
      check_val("echo_count", echo_q.size(), acc_q.size());
      foreach (acc_q[i])
         if (i < echo_q.size()) check_val("echo_byte", echo_q[i], acc_q[i]);
`else
      check_val("tx_tied_low", tx_bad, 0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
